// File: rtl/stall_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
// Holds the memory-wait FSM state encoding and the default data-memory timeout.
package stall_ctrl_pkg;

   localparam int MEM_TIMEOUT_DEF = 15;
   localparam int WAIT_CNT_W      = 8;

   typedef enum logic [1:0] {
      RUN  = 2'd0,
      WAIT = 2'd1,
      ERR  = 2'd2
   } mem_state_e;

   typedef struct packed {
      logic stall_f;
      logic stall_d;
      logic stall_e;
      logic stall_m;
      logic flush_d;
      logic flush_e;
      logic flush_w;
   } ctrl_t;

   // x0 is hard-wired zero, so a load targeting it never creates a hazard.
   function automatic logic load_use_hit(input logic [4:0] rd,
                                         input logic [4:0] rs1,
                                         input logic [4:0] rs2);
      return (rd != 5'd0) && ((rd == rs1) || (rd == rs2));
   endfunction

endpackage

// File: rtl/mem_wait_fsm.sv
// Data-memory wait tracker: MemStall is combinational same-cycle, MemErr is a registered 1-cycle pulse.
// Backpressure: holds the pipeline while an access is outstanding, aborts after MEM_TIMEOUT wait cycles.
module mem_wait_fsm
   import stall_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic req,
   input  logic ready,
   output logic mem_stall,
   output logic mem_err
);

   localparam logic [WAIT_CNT_W-1:0] TIMEOUT_C = WAIT_CNT_W'(MEM_TIMEOUT);

   mem_state_e            state;
   logic [WAIT_CNT_W-1:0] wait_cnt;
   logic                  err_q;

   // The ERR cycle releases the pipeline even though the request is still pending.
   assign mem_stall = !reset && req && !ready && (state != ERR);
   assign mem_err   = err_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= RUN;
         wait_cnt <= '0;
         err_q    <= 1'b0;
      end else begin
         err_q <= 1'b0;
         case (state)
            RUN: begin
               if (req && !ready) begin
                  state    <= WAIT;
                  wait_cnt <= WAIT_CNT_W'(1);
               end
            end
            WAIT: begin
               // A withdrawn request also ends the wait, so no spurious abort follows it.
               if (ready || !req) begin
                  state <= RUN;
               end else if (wait_cnt == TIMEOUT_C) begin
                  state <= ERR;
                  err_q <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + WAIT_CNT_W'(1);
               end
            end
            ERR: begin
               state    <= RUN;
               wait_cnt <= '0;
            end
            default: begin
               state    <= RUN;
               wait_cnt <= '0;
            end
         endcase
      end
   end

endmodule

// File: rtl/stall_ctrl.sv
// Pipeline hazard priority (mem wait > branch > load-use) with optional STALL_CTRL_PERF_EN counters.
// Latency: controls are combinational from inputs; memory waits backpressure F/D/E/M until ready or timeout.
module stall_ctrl
   import stall_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       Rs1D,
   input  logic [4:0]       Rs2D,
   input  logic [4:0]       RdE,
   input  logic             MemReadE,
   input  logic             PCSrcE,
   input  logic             DMemReqM,
   input  logic             DMemReadyM,
   output logic             StallF,
   output logic             StallD,
   output logic             StallE,
   output logic             StallM,
   output logic             FlushD,
   output logic             FlushE,
   output logic             FlushW,
   output logic             MemErr,
   output logic [CNT_W-1:0] StallCnt,
   output logic [CNT_W-1:0] FlushCnt
);

   logic  mem_stall;
   logic  mem_err;
   logic  load_use;
   ctrl_t ctrl;

   mem_wait_fsm #(
      .MEM_TIMEOUT (MEM_TIMEOUT)
   ) u_fsm (
      .clk       (clk),
      .reset     (reset),
      .req       (DMemReqM),
      .ready     (DMemReadyM),
      .mem_stall (mem_stall),
      .mem_err   (mem_err)
   );

   assign load_use = MemReadE && load_use_hit(RdE, Rs1D, Rs2D);

   always_comb begin
      ctrl = '0;
      if (mem_stall) begin
         ctrl.stall_f = 1'b1;
         ctrl.stall_d = 1'b1;
         ctrl.stall_e = 1'b1;
         ctrl.stall_m = 1'b1;
         ctrl.flush_w = 1'b1;
      end else if (PCSrcE) begin
         ctrl.flush_d = 1'b1;
         ctrl.flush_e = 1'b1;
      end else if (load_use) begin
         ctrl.stall_f = 1'b1;
         ctrl.stall_d = 1'b1;
         ctrl.flush_e = 1'b1;
      end
      // The aborted access must not retire into writeback.
      if (mem_err) begin
         ctrl.flush_w = 1'b1;
      end
      if (reset) begin
         ctrl = '0;
      end
   end

   assign StallF = ctrl.stall_f;
   assign StallD = ctrl.stall_d;
   assign StallE = ctrl.stall_e;
   assign StallM = ctrl.stall_m;
   assign FlushD = ctrl.flush_d;
   assign FlushE = ctrl.flush_e;
   assign FlushW = ctrl.flush_w;
   assign MemErr = mem_err && !reset;

`ifdef STALL_CTRL_PERF_EN
   logic [CNT_W-1:0] stall_cnt_q;
   logic [CNT_W-1:0] flush_cnt_q;

   // FlushE with PCSrcE set can only come from the branch leg of the priority chain.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (ctrl.stall_f && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
         end
         if (ctrl.flush_e && PCSrcE && (flush_cnt_q != '1)) begin
            flush_cnt_q <= flush_cnt_q + CNT_W'(1);
         end
      end
   end

   assign StallCnt = stall_cnt_q;
   assign FlushCnt = flush_cnt_q;
`else
   assign StallCnt = '0;
   assign FlushCnt = '0;
`endif

endmodule

// File: doc/stall_ctrl.md
STALL_CTRL -- requirements
Module: stall_ctrl

Interface
REQ-001 Parameter MEM_TIMEOUT, default 15: maximum data-memory wait cycles before abort; legal range 1..255.
REQ-002 Parameter CNT_W, default 32: width of performance counters.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 Rs1D, Rs2D  input  5 each  source register numbers of the instruction in Decode.
REQ-006 RdE  input  5  destination register of the instruction in Execute.
REQ-007 MemReadE  input  1  instruction in Execute is a load.
REQ-008 PCSrcE  input  1  taken branch/jump resolved in Execute.
REQ-009 DMemReqM  input  1  load/store access active in Memory.
REQ-010 DMemReadyM  input  1  data memory completes the access this cycle.
REQ-011 StallF, StallD, StallE, StallM  output  1 each  hold the corresponding pipeline register.
REQ-012 FlushD, FlushE, FlushW  output  1 each  load a bubble into the corresponding pipeline register.
REQ-013 MemErr  output  1  one-cycle pulse: memory access aborted on timeout.
REQ-014 StallCnt, FlushCnt  output  CNT_W each  performance counters (see Configuration).

Function
REQ-015 The FSM SHALL have states RUN, WAIT and ERR, and SHALL hold an 8-bit wait counter.
REQ-016 MemStall = DMemReqM && !DMemReadyM && state != ERR, combinational, same cycle.
REQ-017 Load-use = MemReadE && RdE != 0 && (RdE == Rs1D || RdE == Rs2D).
REQ-018 While MemStall: StallF = StallD = StallE = StallM = 1, FlushW = 1, FlushD = FlushE = 0; load-use and branch actions are suppressed and re-evaluated once MemStall drops.
REQ-019 Otherwise, if PCSrcE: FlushD = FlushE = 1, all stalls 0; the branch wins over a simultaneous load-use.
REQ-020 Otherwise, if load-use: StallF = StallD = 1, FlushE = 1, and all other outputs 0.
REQ-021 Otherwise all stall/flush outputs SHALL be 0.
REQ-022 RUN -> WAIT when MemStall, with counter := 1; RUN holds otherwise.
REQ-023 In WAIT: DMemReadyM -> RUN; else if counter == MEM_TIMEOUT -> ERR; else counter increments.
REQ-024 In ERR: MemErr = 1, FlushW = 1, stalls released for exactly one cycle, then ERR -> RUN unconditionally.
REQ-025 A request completing in the cycle it appears (DMemReadyM = 1) SHALL cause no stall and no state change.
REQ-026 Back-to-back waited accesses SHALL each re-enter WAIT with the counter restarted at 1.

Reset
REQ-027 While reset is high, the state SHALL be RUN, the counter 0, and every output 0, including counters; this applies asynchronously and also mid-WAIT.
REQ-028 After reset falls, the first rising edge SHALL evaluate the inputs from RUN.

Configuration
REQ-029 With STALL_CTRL_PERF_EN defined: StallCnt increments on each cycle with StallF = 1, FlushCnt increments on each cycle with PCSrcE-caused FlushE = 1, and both saturate at all-ones.
REQ-030 Without STALL_CTRL_PERF_EN: no counter flops exist, and StallCnt and FlushCnt SHALL be tied to 0.

Structure
REQ-031 The state enum (RUN/WAIT/ERR) and the default MEM_TIMEOUT constant SHALL live in a shared package, stall_ctrl_pkg.
REQ-032 The FSM plus wait counter SHALL be a sub-module, mem_wait_fsm, producing MemStall and MemErr; the priority logic and counters SHALL remain in stall_ctrl.

Verification
REQ-033 Load-use: RdE=5, MemReadE=1, Rs1D=5 -> StallF=StallD=FlushE=1 for 1 cycle; with RdE=0 -> no stall.
REQ-034 Branch plus load-use together: PCSrcE=1, load-use true -> FlushD=FlushE=1, StallF=0.
REQ-035 Memory wait: DMemReqM=1, DMemReadyM low for 3 cycles then high -> stalls F/D/E/M plus FlushW for 3 cycles, then state RUN.
REQ-036 Timeout with MEM_TIMEOUT=4 and ready held low -> 5 stall cycles (RUN plus 4 WAIT), then one ERR cycle with MemErr=1, FlushW=1, no stall, then RUN.
REQ-037 Reset asserted during WAIT -> outputs 0 immediately, state RUN, counters 0.
REQ-038 Perf on (STALL_CTRL_PERF_EN defined): 3 mem-stall cycles plus 1 branch -> StallCnt=3, FlushCnt=1; counter preloaded near all-ones -> saturates, no wrap.
